wb_mem_arbiter: RTL and testbench

Two-master Wishbone B3 arbiter in front of one memory-controller slave port. Master 0 is the DVGA pixel-fetch DMA (high priority, bursty); master 1 is a general-purpose master such as the CPU data bus or an accelerator. Master 0 has priority, bounded by a fairness counter, so master 1 is never starved. A bus timeout keeps a hung slave from locking up video refresh.

---
 rtl/wb_mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_wb_mem_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_arbiter.sv
// Two-master Wishbone B3 arbiter: master 0 (pixel DMA) has priority, bounded by a
// fairness counter. A bus watchdog aborts a hung slave cycle with an error to the owner.
module wb_mem_arbiter #(
  parameter int unsigned MAX_M0  = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // master 0
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  input  logic [2:0]  m0_cti_i,
  input  logic [1:0]  m0_bte_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  // master 1
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  input  logic [2:0]  m1_cti_i,
  input  logic [1:0]  m1_bte_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  // slave
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  output logic [2:0]  s_cti_o,
  output logic [1:0]  s_bte_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  gnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  localparam logic [3:0] MAX_M0_C  = 4'(MAX_M0);
  localparam logic [9:0] WDOG_LAST = 10'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [9:0]  wdog_q, wdog_d;
  logic        abort_q, abort_d;

  state_t      arb_pick;
  logic        own_cyc, own_stb;
  logic        active, resp_en, expire;
  logic        ack_fwd, err_fwd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      starve_q <= 4'd0;
      wdog_q   <= 10'd0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      wdog_q   <= wdog_d;
      abort_q  <= abort_d;
    end
  end

  // Arbitration decision shared by IDLE and by a same-cycle handover.
  always_comb begin
    arb_pick = IDLE;
    if (m0_cyc_i && (!m1_cyc_i || (starve_q < MAX_M0_C))) begin
      arb_pick = OWN0;
    end else if (m1_cyc_i) begin
      arb_pick = OWN1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb_pick;
      OWN0:    if (!m0_cyc_i) state_d = arb_pick;
      OWN1:    if (!m1_cyc_i) state_d = arb_pick;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (state_d == OWN0 && state_q != OWN0 && m1_cyc_i) begin
      if (starve_q != 4'hF) starve_d = starve_q + 4'd1;
    end else if (state_d == OWN1 && state_q != OWN1) begin
      starve_d = 4'd0;
    end else if (state_q == IDLE && !m1_cyc_i) begin
      starve_d = 4'd0;
    end
  end

  // Owner mux; every slave-side field is zero while idle.
  always_comb begin
    own_cyc = 1'b0;
    own_stb = 1'b0;
    s_adr_o = 32'd0;
    s_dat_o = 32'd0;
    s_sel_o = 4'd0;
    s_we_o  = 1'b0;
    s_cti_o = 3'd0;
    s_bte_o = 2'd0;
    case (state_q)
      OWN0: begin
        own_cyc = m0_cyc_i;
        own_stb = m0_stb_i;
        s_adr_o = m0_adr_i;
        s_dat_o = m0_dat_i;
        s_sel_o = m0_sel_i;
        s_we_o  = m0_we_i;
        s_cti_o = m0_cti_i;
        s_bte_o = m0_bte_i;
      end
      OWN1: begin
        own_cyc = m1_cyc_i;
        own_stb = m1_stb_i;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cti_o = m1_cti_i;
        s_bte_o = m1_bte_i;
      end
      default: ;
    endcase
  end

  // Gating with rst drops the cycle in the very cycle reset is asserted.
  assign active  = rst && (state_q != IDLE);
  assign resp_en = active && !abort_q;
  assign s_cyc_o = resp_en && own_cyc;
  assign s_stb_o = resp_en && own_stb;

  assign ack_fwd = resp_en && s_ack_i;
  assign err_fwd = resp_en && s_err_i;
  // An ack or err arriving on the expiry cycle wins over the timeout.
  assign expire  = resp_en && own_cyc && own_stb && !s_ack_i && !s_err_i &&
                   (wdog_q == WDOG_LAST);

  always_comb begin
    wdog_d = 10'd0;
    if (resp_en && own_cyc && own_stb && !s_ack_i && !s_err_i && !expire) begin
      wdog_d = wdog_q + 10'd1;
    end
  end

  always_comb begin
    abort_d = abort_q;
    if (state_q == IDLE || !own_cyc) begin
      abort_d = 1'b0;
    end else if (expire) begin
      abort_d = 1'b1;
    end
  end

  assign gnt_o    = state_q;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = ack_fwd && (state_q == OWN0);
  assign m1_ack_o = ack_fwd && (state_q == OWN1);
  assign m0_err_o = (err_fwd || expire) && (state_q == OWN0);
  assign m1_err_o = (err_fwd || expire) && (state_q == OWN1);

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Directed bench for wb_mem_arbiter (MAX_M0=2, TIMEOUT=16); the bench plays both
// masters and drives the slave responses cycle by cycle.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [2:0]  m0_cti_i, m1_cti_i;
  logic [1:0]  m0_bte_i, m1_bte_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [1:0]  gnt_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_mem_arbiter #(.MAX_M0(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .gnt_o(gnt_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
    s_ack_i = 1'b1;
    repeat (3) tick();
    settle();
    checks++;
    if (gnt_o !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", gnt_o); end
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      failures++; $display("FAIL reset_scyc got cyc=%b stb=%b exp=0", s_cyc_o, s_stb_o);
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin
      failures++; $display("FAIL reset_resp got=%b exp=0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    s_ack_i = 1'b0;
    rst = 1'b1;
    settle();
    checks++;
    if (gnt_o !== 2'b00) begin failures++; $display("FAIL release_pre_gnt got=%b exp=00", gnt_o); end
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin failures++; $display("FAIL release_gnt got=%b exp=01", gnt_o); end
    $display("reset: released, gnt=%b", gnt_o);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_single_m1_read();
    int acks = 0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_adr_i = 32'h0000_1000;
    tick();
    settle();
    checks++;
    if (gnt_o !== 2'b10 || s_stb_o !== 1'b1 || s_adr_o !== 32'h0000_1000) begin
      failures++; $display("FAIL m1_read_grant got gnt=%b stb=%b adr=%h exp gnt=10 stb=1 adr=00001000", gnt_o, s_stb_o, s_adr_o);
    end
    if (m1_ack_o) acks++;
    tick();
    if (m1_ack_o) acks++;
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    settle();
    if (m1_ack_o) acks++;
    checks++;
    if (m1_dat_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL m1_read_data got=%h exp=deadbeef", m1_dat_o);
    end
    checks++;
    if (m0_ack_o !== 1'b0) begin failures++; $display("FAIL m1_read_m0ack got=%b exp=0", m0_ack_o); end
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    settle();
    if (m1_ack_o) acks++;
    checks++;
    if (acks != 1) begin failures++; $display("FAIL m1_read_ackcount got=%0d exp=1", acks); end
    $display("single m1 read: acks=%0d data=%h", acks, m1_dat_o);
    tick();
    tick();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_gnt [6];
    exp_gnt = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    for (int r = 0; r < 6; r++) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'h0000_2000;
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      tick();
      s_ack_i = 1'b1;
      settle();
      checks++;
      if (gnt_o !== exp_gnt[r]) begin
        failures++; $display("FAIL fair_gnt round=%0d got=%b exp=%b", r, gnt_o, exp_gnt[r]);
      end
      checks++;
      if ({m1_ack_o, m0_ack_o} !== exp_gnt[r]) begin
        failures++; $display("FAIL fair_ack round=%0d got=%b exp=%b", r, {m1_ack_o, m0_ack_o}, exp_gnt[r]);
      end
      $display("fairness round %0d: gnt=%b", r, gnt_o);
      tick();
      s_ack_i = 1'b0;
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
      tick();
    end
    tick();
  endtask

  task automatic test_burst();
    int m0_acks = 0;
    int m1_acks = 0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0; m0_bte_i = 2'b00;
    m0_cti_i = 3'b010; m0_adr_i = 32'h0000_0100;
    tick();
    for (int b = 0; b < 8; b++) begin
      m0_cti_i = (b == 7) ? 3'b111 : 3'b010;
      m0_adr_i = 32'h0000_0100 + 32'(4 * b);
      s_ack_i = 1'b1; s_dat_i = 32'(b);
      if (b == 2) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
      settle();
      if (m0_ack_o) m0_acks++;
      if (m1_ack_o) m1_acks++;
      if (b == 7) begin
        checks++;
        if (s_cti_o !== 3'b111) begin failures++; $display("FAIL burst_cti got=%b exp=111", s_cti_o); end
      end
      tick();
    end
    s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_cti_i = 3'b000;
    settle();
    checks++;
    if (m0_acks != 8 || m1_acks != 0) begin
      failures++; $display("FAIL burst_acks got m0=%0d m1=%0d exp m0=8 m1=0", m0_acks, m1_acks);
    end
    checks++;
    if (gnt_o !== 2'b01) begin failures++; $display("FAIL burst_hold got=%b exp=01", gnt_o); end
    tick();
    checks++;
    if (gnt_o !== 2'b10) begin failures++; $display("FAIL burst_handover got=%b exp=10", gnt_o); end
    $display("burst: m0 acks=%0d m1 acks=%0d handover gnt=%b", m0_acks, m1_acks, gnt_o);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    bit seen = 0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1; m1_adr_i = 32'h0000_3000;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      cnt++;
      settle();
      if (m1_err_o === 1'b1) seen = 1;
    end
    checks++;
    if (!seen || cnt != 16) begin
      failures++; $display("FAIL timeout_latency got seen=%0d cycles=%0d exp seen=1 cycles=16", seen, cnt);
    end
    tick();
    s_ack_i = 1'b1;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    settle();
    checks++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      failures++; $display("FAIL timeout_abort got cyc=%b stb=%b exp=0", s_cyc_o, s_stb_o);
    end
    checks++;
    if (m1_err_o !== 1'b0 || m1_ack_o !== 1'b0) begin
      failures++; $display("FAIL timeout_resp got err=%b ack=%b exp=0", m1_err_o, m1_ack_o);
    end
    tick();
    s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    checks++;
    if (gnt_o !== 2'b01) begin failures++; $display("FAIL timeout_regrant got=%b exp=01", gnt_o); end
    $display("timeout: err after %0d cycles, then gnt=%b", cnt, gnt_o);
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_ack_at_expiry();
    int early_errs = 0;
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (c == 16) s_ack_i = 1'b1;
      settle();
      if (c < 16 && m1_err_o) early_errs++;
    end
    checks++;
    if (m1_ack_o !== 1'b1 || m1_err_o !== 1'b0 || early_errs != 0) begin
      failures++; $display("FAIL expiry_ack got ack=%b err=%b early=%0d exp ack=1 err=0 early=0", m1_ack_o, m1_err_o, early_errs);
    end
    tick();
    s_ack_i = 1'b0;
    settle();
    checks++;
    if (s_stb_o !== 1'b1 || m1_err_o !== 1'b0) begin
      failures++; $display("FAIL expiry_noabort got stb=%b err=%b exp stb=1 err=0", s_stb_o, m1_err_o);
    end
    $display("ack at expiry: stb=%b err=%b", s_stb_o, m1_err_o);
    m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_burst();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    settle();
    checks++;
    if (s_cyc_o !== 1'b0 || m0_err_o !== 1'b0 || m1_err_o !== 1'b0) begin
      failures++; $display("FAIL midrst_drop got cyc=%b err0=%b err1=%b exp=0", s_cyc_o, m0_err_o, m1_err_o);
    end
    tick();
    checks++;
    if (gnt_o !== 2'b00) begin failures++; $display("FAIL midrst_gnt got=%b exp=00", gnt_o); end
    $display("reset mid-burst: gnt=%b cyc=%b", gnt_o, s_cyc_o);
    rst = 1'b1;
    m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = 4'hF; m0_we_i = 1'b0;
    m0_stb_i = 1'b0; m0_cyc_i = 1'b0; m0_cti_i = '0; m0_bte_i = '0;
    m1_adr_i = '0; m1_dat_i = 32'h1234_5678; m1_sel_i = 4'hF; m1_we_i = 1'b0;
    m1_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_cti_i = '0; m1_bte_i = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    test_reset();
    test_single_m1_read();
    test_fairness();
    test_burst();
    test_timeout();
    test_ack_at_expiry();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
